// File: rtl/operand_fetch_stage.sv
// Operand fetch: drives register file reads, forwards EX/MEM/WB results,
// inserts load-use bubbles and holds resolved operands in a valid/ready slot.
module operand_fetch_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   clrn,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic                   in_use_rs1,
    input  logic                   in_use_rs2,
    input  logic [4:0]             in_rd,
    input  logic                   in_reg_write,
    input  logic                   in_mem_read,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_imm,

    output logic [4:0]             rf_rs1,
    output logic [4:0]             rf_rs2,
    input  logic [XLEN-1:0]        rf_data_a,
    input  logic [XLEN-1:0]        rf_data_b,

    input  logic [4:0]             ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic [XLEN-1:0]        ex_result,

    input  logic [4:0]             mem_rd,
    input  logic                   mem_reg_write,
    input  logic [XLEN-1:0]        mem_result,

    input  logic [4:0]             wb_rd,
    input  logic                   wb_reg_write,
    input  logic [XLEN-1:0]        wb_data,

    input  logic                   flush,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_op_a,
    output logic [XLEN-1:0]        out_op_b,
    output logic [4:0]             out_rd,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_imm,

    output logic [STALL_CNT_W-1:0] stall_count
);

    logic            ex_fwd_ok;
    logic            ex_load;
    logic            lu_rs1;
    logic            lu_rs2;
    logic            load_use;
    logic            accept;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    // A load in EX has no data yet, so it never forwards from EX.
    assign ex_fwd_ok = ex_reg_write && !ex_mem_read;
    assign ex_load   = ex_mem_read && ex_reg_write && (ex_rd != 5'd0);

    assign lu_rs1   = in_use_rs1 && (ex_rd == in_rs1);
    assign lu_rs2   = in_use_rs2 && (ex_rd == in_rs2);
    assign load_use = ex_load && in_valid && (lu_rs1 || lu_rs2);

    assign in_ready = !flush && !load_use && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_a = rf_data_a;
        if (in_rs1 == 5'd0) begin
            op_a = '0;
        end else if (ex_fwd_ok && (ex_rd == in_rs1)) begin
            op_a = ex_result;
        end else if (mem_reg_write && (mem_rd == in_rs1)) begin
            op_a = mem_result;
        end else if (wb_reg_write && (wb_rd == in_rs1)) begin
            op_a = wb_data;
        end
    end

    always_comb begin
        op_b = rf_data_b;
        if (in_rs2 == 5'd0) begin
            op_b = '0;
        end else if (ex_fwd_ok && (ex_rd == in_rs2)) begin
            op_b = ex_result;
        end else if (mem_reg_write && (mem_rd == in_rs2)) begin
            op_b = mem_result;
        end else if (wb_reg_write && (wb_rd == in_rs2)) begin
            op_b = wb_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid     <= 1'b0;
            out_op_a      <= '0;
            out_op_b      <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_pc        <= '0;
            out_imm       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_op_a      <= op_a;
            out_op_b      <= op_b;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
            out_mem_read  <= in_mem_read;
            out_pc        <= in_pc;
            out_imm       <= in_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_count <= '0;
        end else if (load_use && !flush && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a scoreboard queue of
// expected slot contents and an independent forwarding/handshake model.
module tb_operand_fetch_stage;

    localparam int XLEN = 32;
    localparam int SW   = 16;

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } slot_t;

    logic            clk = 1'b0;
    logic            clrn;
    logic            in_valid, in_ready;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_use_rs1, in_use_rs2, in_reg_write, in_mem_read;
    logic [XLEN-1:0] in_pc, in_imm;
    logic [4:0]      rf_rs1, rf_rs2;
    logic [XLEN-1:0] rf_data_a, rf_data_b;
    logic [4:0]      ex_rd, mem_rd, wb_rd;
    logic            ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic [XLEN-1:0] ex_result, mem_result, wb_data;
    logic            flush;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_op_a, out_op_b, out_pc, out_imm;
    logic [4:0]      out_rd;
    logic            out_reg_write, out_mem_read;
    logic [SW-1:0]   stall_count;

    logic [XLEN-1:0] rf [32];

    int    vectors = 0;
    int    errors  = 0;
    slot_t sb_q[$];
    slot_t cur;
    logic  exp_valid;
    logic  [SW-1:0] exp_cnt;

    always #5 clk = ~clk;

    assign rf_data_a = rf[rf_rs1];
    assign rf_data_b = rf[rf_rs2];

    operand_fetch_stage #(.XLEN(XLEN), .STALL_CNT_W(SW)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_pc(in_pc), .in_imm(in_imm),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read),
        .out_pc(out_pc), .out_imm(out_imm),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] s);
        if (s == 0) return '0;
        if (ex_reg_write && !ex_mem_read && ex_rd == s) return ex_result;
        if (mem_reg_write && mem_rd == s) return mem_result;
        if (wb_reg_write && wb_rd == s) return wb_data;
        return rf[s];
    endfunction

    function automatic logic model_lu();
        return ex_mem_read && ex_reg_write && ex_rd != 0 && in_valid &&
               ((in_use_rs1 && ex_rd == in_rs1) ||
                (in_use_rs2 && ex_rd == in_rs2));
    endfunction

    task automatic check_slot(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
        chk({tag, ".stall"}, 64'(stall_count), 64'(exp_cnt));
        if (exp_valid) begin
            chk({tag, ".op_a"}, 64'(out_op_a), 64'(cur.op_a));
            chk({tag, ".op_b"}, 64'(out_op_b), 64'(cur.op_b));
            chk({tag, ".rd"},   64'(out_rd),   64'(cur.rd));
            chk({tag, ".rw"},   64'(out_reg_write), 64'(cur.rw));
            chk({tag, ".mr"},   64'(out_mem_read),  64'(cur.mr));
            chk({tag, ".pc"},   64'(out_pc),   64'(cur.pc));
            chk({tag, ".imm"},  64'(out_imm),  64'(cur.imm));
        end
    endtask

    // One clock: check handshake before the edge, update model, check after.
    task automatic cycle(input string tag);
        logic lu, rdy, acc;
        slot_t e;
        #1;
        lu  = model_lu();
        rdy = !flush && !lu && (!exp_valid || out_ready);
        acc = in_valid && rdy;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        chk({tag, ".rf_rs1"}, 64'(rf_rs1), 64'(in_rs1));
        if (acc) begin
            e.op_a = fwd(in_rs1);
            e.op_b = fwd(in_rs2);
            e.rd   = in_rd;
            e.rw   = in_reg_write;
            e.mr   = in_mem_read;
            e.pc   = in_pc;
            e.imm  = in_imm;
            sb_q.push_back(e);
        end
        if (lu && !flush && exp_cnt != '1) exp_cnt++;
        @(posedge clk);
        #1;
        if (flush) exp_valid = 1'b0;
        else if (acc) begin
            cur = sb_q.pop_front();
            exp_valid = 1'b1;
        end else if (out_ready) exp_valid = 1'b0;
        check_slot(tag);
    endtask

    task automatic no_prod();
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_result = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [XLEN-1:0] pc);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2;
        in_use_rs1 = 1; in_use_rs2 = 1;
        in_rd = rd; in_reg_write = 1; in_mem_read = 0;
        in_pc = pc; in_imm = pc ^ 32'h0F0F_0F0F;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'h11;
        rf[3] = 32'h01;
        clrn = 0; flush = 0; out_ready = 1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_reg_write = 0; in_mem_read = 0;
        in_pc = 0; in_imm = 0;
        no_prod();
        exp_valid = 0; exp_cnt = 0;
        #12;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.op_a", 64'(out_op_a), 64'd0);
        chk("rst.pc", 64'(out_pc), 64'd0);
        chk("rst.stall", 64'(stall_count), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        clrn = 1;
        @(posedge clk); #1;

        instr(5, 0, 1, 32'h100);
        cycle("t1_rf");

        instr(5, 6, 2, 32'h104);
        ex_rd = 5; ex_reg_write = 1; ex_result = 32'hAA;
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'hBB;
        wb_rd = 5; wb_reg_write = 1; wb_data = 32'hCC;
        cycle("t2_ex");
        ex_reg_write = 0;
        instr(5, 6, 2, 32'h108);
        cycle("t2_mem");
        mem_reg_write = 0;
        cycle("t2_wb");

        no_prod();
        instr(1, 7, 4, 32'h10C);
        ex_rd = 7; ex_reg_write = 1; ex_mem_read = 1; ex_result = 32'hBAD;
        cycle("t3_lu");
        no_prod();
        mem_rd = 7; mem_reg_write = 1; mem_result = 32'h42;
        cycle("t3_fwd");

        no_prod();
        ex_rd = 7; ex_reg_write = 1; ex_mem_read = 1;
        instr(1, 7, 4, 32'h110);
        in_use_rs2 = 0;
        cycle("t3_nouse");
        ex_rd = 0;
        instr(0, 0, 4, 32'h114);
        cycle("t3_x0load");

        no_prod();
        wb_rd = 3; wb_reg_write = 1; wb_data = 32'h99;
        instr(3, 5, 8, 32'h118);
        cycle("t4_wb");
        no_prod();
        ex_reg_write = 1; ex_result = 32'h55;
        mem_reg_write = 1; mem_result = 32'h66;
        wb_reg_write = 1; wb_data = 32'h77;
        instr(0, 0, 9, 32'h11C);
        cycle("t4_x0");

        no_prod();
        out_ready = 0;
        instr(5, 3, 10, 32'h120);
        cycle("t5_load");
        for (int i = 0; i < 3; i++) begin
            instr(6, 7, 11, 32'h200 + 4 * i);
            cycle("t5_hold");
        end
        flush = 1;
        cycle("t5_flush");
        flush = 0;

        out_ready = 1;
        instr(6, 5, 12, 32'h300);
        cycle("t6_fill");
        ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
        instr(5, 0, 13, 32'h304);
        cycle("t6_stall");
        #3;
        clrn = 0;
        #1;
        chk("t6.valid", 64'(out_valid), 64'd0);
        chk("t6.stall", 64'(stall_count), 64'd0);
        chk("t6.op_a", 64'(out_op_a), 64'd0);
        chk("t6.rd", 64'(out_rd), 64'd0);
        @(posedge clk); #1;
        clrn = 1;
        exp_valid = 0; exp_cnt = 0;
        sb_q.delete();
        no_prod();
        instr(5, 3, 14, 32'h400);
        cycle("t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
